// File: rtl/compair_readout_pkg.sv
// Shared types and helpers for the AstroPix layer readout scheduler.
package compair_readout_pkg;

  localparam int unsigned NLAYERS_DEFAULT = 20;
  localparam int unsigned LAYER_IDX_W     = $clog2(NLAYERS_DEFAULT);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HOLD_SETUP,
    ST_REQ,
    ST_READ,
    ST_RELEASE
  } sched_state_t;

  // (base + step) mod n, valid for base < n and step <= n
  function automatic int unsigned rr_wrap(input int unsigned base,
                                          input int unsigned step,
                                          input int unsigned n);
    int unsigned s;
    s = base + step;
    return (s >= n) ? s - n : s;
  endfunction

endpackage

// File: rtl/layer_readout_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first pending index after last_grant, wrapping.
module rr_arbiter
  import compair_readout_pkg::*;
#(
  parameter int unsigned N     = NLAYERS_DEFAULT,
  parameter int unsigned IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     pending,
  input  logic [IDX_W-1:0] last_grant,
  output logic             found,
  output logic [IDX_W-1:0] grant_idx
);

  logic [IDX_W-1:0] cand;

  // Scan farthest-first so the nearest pending candidate is the last write
  always_comb begin
    found     = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int unsigned k = N; k >= 1; k--) begin
      cand = IDX_W'(rr_wrap(32'(last_grant), k, N));
      if (pending[cand]) begin
        found     = 1'b1;
        grant_idx = cand;
      end
    end
  end

endmodule

// File: rtl/sync_cell.sv
// Shared multi-bit synchronizer cell: STAGES flops per bit, per-bit reset value.
module sync_cell #(
  parameter int unsigned       WIDTH   = 1,
  parameter int unsigned       STAGES  = 2,
  parameter logic [WIDTH-1:0]  RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] ff [STAGES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < STAGES; i++) ff[i] <= RST_VAL;
    end else begin
      ff[0] <= d;
      for (int unsigned i = 1; i < STAGES; i++) ff[i] <= ff[i-1];
    end
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/layer_readout_scheduler.sv
// Arbitrates the AstroPix layers onto the shared SPI readout engine:
// hold, request/ack/done handshake and a transfer timeout.
module layer_readout_scheduler
  import compair_readout_pkg::*;
#(
  parameter int unsigned NLAYERS     = NLAYERS_DEFAULT,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned HOLD_SETUP  = 4,
  parameter int unsigned TO_W        = 16
) (
  input  logic                       sysclk,
  input  logic                       resn,
  input  logic                       enable,
  input  logic [NLAYERS-1:0]         layer_mask,
  input  logic [NLAYERS-1:0]         hold_force,
  input  logic [TO_W-1:0]            timeout_cycles,
  input  logic [NLAYERS-1:0]         layer_interruptn,
  output logic [NLAYERS-1:0]         layer_hold,
  output logic                       rd_req,
  output logic [$clog2(NLAYERS)-1:0] rd_layer,
  input  logic                       rd_ack,
  input  logic                       rd_done,
  output logic                       rd_abort,
  output logic                       busy,
  output logic                       timeout_evt,
  output logic [7:0]                 timeout_count
);

  localparam int unsigned IDX_W = $clog2(NLAYERS);
  localparam int unsigned HS_W  = 4;
  localparam int unsigned TC_W  = 8;

  logic [NLAYERS-1:0] int_sync;
  logic [NLAYERS-1:0] pending;
  logic               arb_found;
  logic [IDX_W-1:0]   arb_idx;

  sched_state_t       state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [IDX_W-1:0]   last_grant_q, last_grant_d;
  logic [HS_W-1:0]    hs_cnt_q, hs_cnt_d;
  logic [TO_W-1:0]    to_cnt_q, to_cnt_d;
  logic [NLAYERS-1:0] hold_q, hold_d;
  logic               rd_req_d;
  logic [IDX_W-1:0]   rd_layer_d;
  logic               busy_d;
  logic               timeout_evt_d;
  logic [TC_W-1:0]    timeout_count_d;
  logic [TO_W:0]      to_next_c;
  logic               to_expire_c;

  // Interrupts idle high, so the synchronizer resets to "no interrupt"
  sync_cell #(
    .WIDTH   (NLAYERS),
    .STAGES  (SYNC_STAGES),
    .RST_VAL ({NLAYERS{1'b1}})
  ) u_int_sync (
    .clk   (sysclk),
    .rst_n (resn),
    .d     (layer_interruptn),
    .q     (int_sync)
  );

  assign pending = ~int_sync & layer_mask;

  rr_arbiter #(
    .N     (NLAYERS),
    .IDX_W (IDX_W)
  ) u_rr_arbiter (
    .pending    (pending),
    .last_grant (last_grant_q),
    .found      (arb_found),
    .grant_idx  (arb_idx)
  );

  assign to_next_c   = {1'b0, to_cnt_q} + (TO_W+1)'(1);
  assign to_expire_c = (timeout_cycles != '0) && (to_next_c == {1'b0, timeout_cycles});

  // Next-state and registered-output decode
  always_comb begin
    state_d         = state_q;
    idx_d           = idx_q;
    last_grant_d    = last_grant_q;
    hs_cnt_d        = hs_cnt_q;
    to_cnt_d        = to_cnt_q;
    timeout_evt_d   = 1'b0;
    timeout_count_d = timeout_count;
    hold_d          = '0;

    unique case (state_q)
      ST_IDLE: begin
        if (enable && arb_found) begin
          idx_d    = arb_idx;
          hs_cnt_d = '0;
          state_d  = ST_HOLD_SETUP;
        end
      end
      ST_HOLD_SETUP: begin
        if (!pending[idx_q]) begin
          state_d = ST_RELEASE;
        end else if (hs_cnt_q == HS_W'(HOLD_SETUP - 1)) begin
          to_cnt_d = '0;
          state_d  = ST_REQ;
        end else begin
          hs_cnt_d = hs_cnt_q + HS_W'(1);
        end
      end
      ST_REQ: begin
        to_cnt_d = to_cnt_q + TO_W'(1);
        if (rd_done) begin
          state_d = ST_RELEASE;
        end else if (to_expire_c) begin
          timeout_evt_d = 1'b1;
          state_d       = ST_RELEASE;
        end else if (rd_ack) begin
          state_d = ST_READ;
        end
      end
      ST_READ: begin
        to_cnt_d = to_cnt_q + TO_W'(1);
        if (rd_done) begin
          state_d = ST_RELEASE;
        end else if (to_expire_c) begin
          timeout_evt_d = 1'b1;
          state_d       = ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        last_grant_d = idx_q;
        state_d      = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (timeout_evt_d && (timeout_count != 8'hFF)) begin
      timeout_count_d = timeout_count + TC_W'(1);
    end

    if (state_d inside {ST_HOLD_SETUP, ST_REQ, ST_READ}) begin
      hold_d[idx_d] = 1'b1;
    end
    rd_req_d   = (state_d == ST_REQ);
    busy_d     = (state_d != ST_IDLE);
    rd_layer_d = (state_d != ST_IDLE) ? idx_d : '0;
  end

  always_ff @(posedge sysclk or negedge resn) begin
    if (!resn) begin
      state_q       <= ST_IDLE;
      idx_q         <= '0;
      last_grant_q  <= IDX_W'(NLAYERS - 1);
      hs_cnt_q      <= '0;
      to_cnt_q      <= '0;
      hold_q        <= '0;
      rd_req        <= 1'b0;
      rd_layer      <= '0;
      busy          <= 1'b0;
      timeout_evt   <= 1'b0;
      rd_abort      <= 1'b0;
      timeout_count <= '0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      last_grant_q  <= last_grant_d;
      hs_cnt_q      <= hs_cnt_d;
      to_cnt_q      <= to_cnt_d;
      hold_q        <= hold_d;
      rd_req        <= rd_req_d;
      rd_layer      <= rd_layer_d;
      busy          <= busy_d;
      timeout_evt   <= timeout_evt_d;
      rd_abort      <= timeout_evt_d;
      timeout_count <= timeout_count_d;
    end
  end

  // Software-forced holds bypass the FSM and reset
  assign layer_hold = hold_q | hold_force;

endmodule

// File: tb/tb_layer_readout_scheduler.sv
// Self-checking bench for layer_readout_scheduler with a round-robin reference model.
module tb_layer_readout_scheduler;

  localparam int N  = 20;
  localparam int HS = 4;
  localparam int SS = 2;

  logic          sysclk;
  logic          resn;
  logic          enable;
  logic [N-1:0]  layer_mask;
  logic [N-1:0]  hold_force;
  logic [15:0]   timeout_cycles;
  logic [N-1:0]  layer_interruptn;
  logic [N-1:0]  layer_hold;
  logic          rd_req;
  logic [4:0]    rd_layer;
  logic          rd_ack;
  logic          rd_done;
  logic          rd_abort;
  logic          busy;
  logic          timeout_evt;
  logic [7:0]    timeout_count;

  int total = 0;
  int bad   = 0;
  int model_last;
  int exp_tmo;

  layer_readout_scheduler #(
    .NLAYERS     (N),
    .SYNC_STAGES (SS),
    .HOLD_SETUP  (HS),
    .TO_W        (16)
  ) dut (
    .sysclk           (sysclk),
    .resn             (resn),
    .enable           (enable),
    .layer_mask       (layer_mask),
    .hold_force       (hold_force),
    .timeout_cycles   (timeout_cycles),
    .layer_interruptn (layer_interruptn),
    .layer_hold       (layer_hold),
    .rd_req           (rd_req),
    .rd_layer         (rd_layer),
    .rd_ack           (rd_ack),
    .rd_done          (rd_done),
    .rd_abort         (rd_abort),
    .busy             (busy),
    .timeout_evt      (timeout_evt),
    .timeout_count    (timeout_count)
  );

  initial begin
    sysclk = 1'b0;
    forever #5 sysclk = ~sysclk;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge sysclk);
      #1;
    end
  endtask

  task automatic do_reset();
    enable           = 1'b1;
    layer_mask       = '1;
    hold_force       = '0;
    timeout_cycles   = '0;
    layer_interruptn = '1;
    rd_ack           = 1'b0;
    rd_done          = 1'b0;
    resn             = 1'b0;
    step(1);
    resn       = 1'b1;
    model_last = N - 1;
    exp_tmo    = 0;
  endtask

  task automatic wait_req(input int budget, output bit ok);
    int c;
    c = 0;
    while (rd_req !== 1'b1 && c < budget) begin
      step(1);
      c++;
    end
    ok = (rd_req === 1'b1);
  endtask

  task automatic serve(input int ack_dly, input int done_dly);
    step(ack_dly);
    rd_ack = 1'b1;
    step(1);
    rd_ack = 1'b0;
    step(done_dly);
    rd_done = 1'b1;
    step(1);
    rd_done = 1'b0;
  endtask

  // Reference: first pending layer strictly after last, wrapping modulo N
  function automatic int rr_pick(input logic [N-1:0] pend, input int last);
    int c;
    for (int k = 1; k <= N; k++) begin
      c = (last + k) % N;
      if (pend[c]) return c;
    end
    return -1;
  endfunction

  task automatic test_reset();
    resn             = 1'b0;
    enable           = 1'b1;
    layer_mask       = '1;
    timeout_cycles   = '0;
    layer_interruptn = '1;
    rd_ack           = 1'b0;
    rd_done          = 1'b0;
    hold_force       = N'($urandom);
    #2;
    total++;
    if (layer_hold !== hold_force) begin
      bad++; $display("FAIL reset_hold: got %h expected %h", layer_hold, hold_force);
    end
    total++;
    if ({rd_req, busy, timeout_evt, rd_abort} !== 4'b0) begin
      bad++; $display("FAIL reset_flags: got %b expected 0000", {rd_req, busy, timeout_evt, rd_abort});
    end
    total++;
    if (rd_layer !== 5'd0 || timeout_count !== 8'd0) begin
      bad++; $display("FAIL reset_values: rd_layer=%0d tcount=%0d expected 0 0", rd_layer, timeout_count);
    end
    hold_force = ~hold_force;
    #1;
    total++;
    if (layer_hold !== hold_force) begin
      bad++; $display("FAIL reset_hold_force_or: got %h expected %h", layer_hold, hold_force);
    end
    step(2);
    do_reset();
  endtask

  task automatic test_single_layer();
    do_reset();
    step(3);
    layer_interruptn[5] = 1'b0;
    step(2);
    total++;
    if (layer_hold !== '0) begin
      bad++; $display("FAIL single_hold_early: got %h expected 0", layer_hold);
    end
    step(1);
    total++;
    if (layer_hold !== N'(1) << 5 || busy !== 1'b1) begin
      bad++; $display("FAIL single_hold_rise: hold=%h busy=%b expected %h 1", layer_hold, busy, N'(1) << 5);
    end
    step(HS - 1);
    total++;
    if (rd_req !== 1'b0) begin
      bad++; $display("FAIL single_req_early: got %b expected 0", rd_req);
    end
    step(1);
    total++;
    if (rd_req !== 1'b1 || int'(rd_layer) !== 5) begin
      bad++; $display("FAIL single_req: rd_req=%b rd_layer=%0d expected 1 5", rd_req, rd_layer);
    end
    step(2);
    rd_ack = 1'b1;
    layer_interruptn[5] = 1'b1;
    step(1);
    rd_ack = 1'b0;
    total++;
    if (rd_req !== 1'b0 || busy !== 1'b1 || layer_hold !== N'(1) << 5) begin
      bad++; $display("FAIL single_read: rd_req=%b busy=%b hold=%h", rd_req, busy, layer_hold);
    end
    step(9);
    rd_done = 1'b1;
    step(1);
    rd_done = 1'b0;
    total++;
    if (layer_hold !== '0 || busy !== 1'b1 || int'(rd_layer) !== 5) begin
      bad++; $display("FAIL single_release: hold=%h busy=%b rd_layer=%0d expected 0 1 5", layer_hold, busy, rd_layer);
    end
    step(1);
    total++;
    if (busy !== 1'b0 || rd_layer !== 5'd0) begin
      bad++; $display("FAIL single_idle: busy=%b rd_layer=%0d expected 0 0", busy, rd_layer);
    end
    model_last = 5;
  endtask

  task automatic test_round_robin();
    logic [N-1:0] pend;
    bit ok;
    int exp;
    do_reset();
    layer_interruptn[0]  = 1'b0;
    layer_interruptn[7]  = 1'b0;
    layer_interruptn[19] = 1'b0;
    pend = ~layer_interruptn & layer_mask;
    for (int g = 0; g < 6; g++) begin
      wait_req(40, ok);
      total++;
      if (!ok) begin
        bad++; $display("FAIL rr_wait: no rd_req for grant %0d", g);
      end
      exp = rr_pick(pend, model_last);
      total++;
      if (int'(rd_layer) !== exp || layer_hold !== N'(1) << exp) begin
        bad++; $display("FAIL rr_order: grant %0d rd_layer=%0d hold=%h expected %0d", g, rd_layer, layer_hold, exp);
      end
      serve(int'($urandom_range(0, 3)), int'($urandom_range(0, 6)));
      model_last = exp;
    end
  endtask

  task automatic test_timeout();
    bit ok;
    bit early;
    do_reset();
    timeout_cycles = 16'd20;
    layer_interruptn[2] = 1'b0;
    wait_req(40, ok);
    total++;
    if (!ok) begin
      bad++; $display("FAIL tmo_wait: no rd_req");
    end
    rd_ack = 1'b1;
    layer_interruptn[2] = 1'b1;
    step(1);
    rd_ack = 1'b0;
    early = 1'b0;
    for (int c = 2; c <= 20; c++) begin
      step(1);
      if (c < 20 && (timeout_evt === 1'b1 || rd_abort === 1'b1)) early = 1'b1;
    end
    total++;
    if (early !== 1'b0) begin
      bad++; $display("FAIL tmo_early: got early pulse expected none");
    end
    exp_tmo++;
    total++;
    if (timeout_evt !== 1'b1 || rd_abort !== 1'b1) begin
      bad++; $display("FAIL tmo_pulse: evt=%b abort=%b expected 1 1", timeout_evt, rd_abort);
    end
    total++;
    if (int'(timeout_count) !== exp_tmo || layer_hold !== '0) begin
      bad++; $display("FAIL tmo_count: count=%0d hold=%h expected %0d 0", timeout_count, layer_hold, exp_tmo);
    end
    step(1);
    total++;
    if (timeout_evt !== 1'b0 || rd_abort !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL tmo_after: evt=%b abort=%b busy=%b expected 0 0 0", timeout_evt, rd_abort, busy);
    end
    model_last = 2;
  endtask

  task automatic test_collision();
    bit ok;
    layer_interruptn[9] = 1'b0;
    wait_req(40, ok);
    total++;
    if (!ok || int'(rd_layer) !== 9) begin
      bad++; $display("FAIL coll_wait: ok=%b rd_layer=%0d expected 1 9", ok, rd_layer);
    end
    rd_ack = 1'b1;
    layer_interruptn[9] = 1'b1;
    step(1);
    rd_ack = 1'b0;
    for (int c = 2; c <= 19; c++) step(1);
    rd_done = 1'b1;
    step(1);
    rd_done = 1'b0;
    total++;
    if (timeout_evt !== 1'b0 || rd_abort !== 1'b0 || int'(timeout_count) !== exp_tmo) begin
      bad++; $display("FAIL coll_done_wins: evt=%b abort=%b count=%0d expected 0 0 %0d", timeout_evt, rd_abort, timeout_count, exp_tmo);
    end
    total++;
    if (layer_hold !== '0 || busy !== 1'b1) begin
      bad++; $display("FAIL coll_release: hold=%h busy=%b expected 0 1", layer_hold, busy);
    end
    step(1);
    model_last = 9;
  endtask

  task automatic test_mask_enable();
    bit ok;
    do_reset();
    layer_mask[3] = 1'b0;
    layer_interruptn[3] = 1'b0;
    step(20);
    total++;
    if (busy !== 1'b0 || layer_hold !== '0) begin
      bad++; $display("FAIL mask_no_grant: busy=%b hold=%h expected 0 0", busy, layer_hold);
    end
    layer_interruptn[3] = 1'b1;
    step(3);
    layer_mask = '1;
    layer_interruptn[11] = 1'b0;
    wait_req(40, ok);
    total++;
    if (!ok || int'(rd_layer) !== 11) begin
      bad++; $display("FAIL en_first_grant: ok=%b rd_layer=%0d expected 1 11", ok, rd_layer);
    end
    rd_ack = 1'b1;
    step(1);
    rd_ack = 1'b0;
    enable = 1'b0;
    step(3);
    rd_done = 1'b1;
    step(1);
    rd_done = 1'b0;
    total++;
    if (layer_hold !== '0 || busy !== 1'b1) begin
      bad++; $display("FAIL en_inflight_completes: hold=%h busy=%b expected 0 1", layer_hold, busy);
    end
    step(20);
    total++;
    if (busy !== 1'b0 || rd_req !== 1'b0 || layer_hold !== '0) begin
      bad++; $display("FAIL en_no_new_grant: busy=%b rd_req=%b hold=%h expected 0 0 0", busy, rd_req, layer_hold);
    end
    enable = 1'b1;
    wait_req(40, ok);
    total++;
    if (!ok || int'(rd_layer) !== 11) begin
      bad++; $display("FAIL en_regrant: ok=%b rd_layer=%0d expected 1 11", ok, rd_layer);
    end
    rd_ack = 1'b1;
    step(1);
    rd_ack = 1'b0;
    layer_mask[11] = 1'b0;
    step(2);
    total++;
    if (layer_hold !== N'(1) << 11 || busy !== 1'b1) begin
      bad++; $display("FAIL mask_mid_transfer: hold=%h busy=%b expected %h 1", layer_hold, busy, N'(1) << 11);
    end
    rd_done = 1'b1;
    step(1);
    rd_done = 1'b0;
    layer_interruptn[11] = 1'b1;
    step(4);
    total++;
    if (busy !== 1'b0 || layer_hold !== '0) begin
      bad++; $display("FAIL mask_after_release: busy=%b hold=%h expected 0 0", busy, layer_hold);
    end
    layer_mask = '1;
  endtask

  task automatic test_reset_mid_read();
    bit ok;
    int a;
    int b;
    int exp;
    do_reset();
    a = int'($urandom_range(0, N - 1));
    b = (a + 1 + int'($urandom_range(0, N - 2))) % N;
    exp = (a < b) ? a : b;
    layer_interruptn[a] = 1'b0;
    layer_interruptn[b] = 1'b0;
    wait_req(40, ok);
    total++;
    if (!ok || int'(rd_layer) !== exp) begin
      bad++; $display("FAIL rst_first: ok=%b rd_layer=%0d expected 1 %0d", ok, rd_layer, exp);
    end
    rd_ack = 1'b1;
    step(1);
    rd_ack = 1'b0;
    step(2);
    #3;
    resn = 1'b0;
    #1;
    total++;
    if (rd_req !== 1'b0 || busy !== 1'b0 || layer_hold !== '0 || rd_layer !== 5'd0) begin
      bad++; $display("FAIL rst_async: rd_req=%b busy=%b hold=%h rd_layer=%0d expected all 0", rd_req, busy, layer_hold, rd_layer);
    end
    step(1);
    resn = 1'b1;
    model_last = N - 1;
    wait_req(40, ok);
    total++;
    if (!ok || int'(rd_layer) !== exp) begin
      bad++; $display("FAIL rst_regrant_lowest: ok=%b rd_layer=%0d expected 1 %0d", ok, rd_layer, exp);
    end
  endtask

  task automatic test_random_traffic();
    logic [N-1:0] pend;
    logic [N-1:0] oh;
    bit ok;
    int exp;
    int r;
    do_reset();
    for (int round = 0; round < 3; round++) begin
      enable           = 1'b0;
      layer_interruptn = ~(N'($urandom) & N'($urandom));
      layer_mask       = ~(N'($urandom) & N'($urandom) & N'($urandom));
      hold_force       = N'($urandom) & N'($urandom) & N'($urandom);
      if ((~layer_interruptn & layer_mask) == '0) begin
        r = int'($urandom_range(0, N - 1));
        layer_interruptn[r] = 1'b0;
        layer_mask[r]       = 1'b1;
      end
      pend = ~layer_interruptn & layer_mask;
      step(SS + 2);
      enable = 1'b1;
      for (int g = 0; g < 5; g++) begin
        wait_req(40, ok);
        total++;
        if (!ok) begin
          bad++; $display("FAIL rand_wait: round %0d grant %0d no rd_req", round, g);
        end
        exp = rr_pick(pend, model_last);
        oh  = N'(1) << exp;
        total++;
        if (int'(rd_layer) !== exp || layer_hold !== (oh | hold_force)) begin
          bad++; $display("FAIL rand_grant: round %0d grant %0d rd_layer=%0d hold=%h expected %0d %h", round, g, rd_layer, layer_hold, exp, oh | hold_force);
        end
        if ($urandom_range(0, 3) == 0) begin
          rd_done = 1'b1;
          step(1);
          rd_done = 1'b0;
          total++;
          if (rd_req !== 1'b0 || (layer_hold & ~hold_force) !== '0) begin
            bad++; $display("FAIL rand_done_before_ack: rd_req=%b hold=%h expected 0 %h", rd_req, layer_hold, hold_force);
          end
        end else begin
          serve(int'($urandom_range(0, 3)), int'($urandom_range(0, 5)));
        end
        model_last = exp;
      end
      enable = 1'b0;
      step(2);
    end
  endtask

  initial begin
    test_reset();
    test_single_layer();
    test_round_robin();
    test_timeout();
    test_collision();
    test_mask_enable();
    test_reset_mid_read();
    test_random_traffic();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/layer_readout_scheduler.md
Name: layer_readout_scheduler

Overview:
- Sequences readout of the 20 AstroPix layers (rows) that share one SPI readout engine in the astep24_20l design.
- Watches each layer's active-low interrupt and picks one pending layer at a time, round-robin.
- Asserts that layer's hold, hands the layer index to the shared readout engine with a request/ack/done handshake, and supervises the transfer with a timeout.
- Sits between the per-layer IO (layer_N_interruptn, layer_N_hold) and the readout engine / register file.

Parameters:
- NLAYERS, 20, number of layers arbitrated.
- SYNC_STAGES, 2, synchronizer flops on each interruptn input.
- HOLD_SETUP, 4, cycles that hold is asserted before rd_req rises (range 1..15).
- TO_W, 16, width of the timeout counter.

Ports:
- sysclk  in  1  system clock.
- resn  in  1  asynchronous active-low reset.
- enable  in  1  register bit; allows new grants.
- layer_mask  in  NLAYERS  register; 1 = layer participates.
- hold_force  in  NLAYERS  register; ORed into layer_hold.
- timeout_cycles  in  TO_W  register; 0 disables the timeout.
- layer_interruptn  in  NLAYERS  asynchronous chip interrupts, active low.
- layer_hold  out  NLAYERS  per-layer hold.
- rd_req  out  1  request to the readout engine.
- rd_layer  out  $clog2(NLAYERS)  layer index being read; stable while rd_req or busy.
- rd_ack  in  1  engine accepted the request.
- rd_done  in  1  engine finished (1-cycle pulse).
- rd_abort  out  1  1-cycle pulse; engine must drop the transfer.
- busy  out  1  FSM not in IDLE.
- timeout_evt  out  1  1-cycle pulse on timeout.
- timeout_count  out  8  saturating count of timeouts.

Behaviour:
- Reset (async, resn low):
  - All outputs 0 except layer_hold = hold_force (combinational OR); last_grant = NLAYERS-1; FSM = IDLE.
  - Reset mid-transfer drops hold and rd_req immediately.
- Interrupt synchronization and pending:
  - Each interruptn passes through SYNC_STAGES flops.
  - pending[i] = ~int_sync[i] & layer_mask[i].
- Arbitration:
  - Round-robin: search starts at (last_grant+1) mod NLAYERS and wraps.
  - The first pending layer wins.
- FSM:
  - IDLE: if enable and |pending, latch idx and go to HOLD_SETUP; layer_hold[idx] rises on the next edge. Otherwise stay.
  - HOLD_SETUP: count HOLD_SETUP cycles, then go to REQ. If pending[idx] deasserts during this state, go to RELEASE without rd_req.
  - REQ: rd_req = 1 until rd_ack is sampled high, then READ. rd_done together with or before rd_ack goes straight to RELEASE.
  - READ: wait for rd_done, then RELEASE.
  - RELEASE: one cycle; layer_hold[idx] falls; last_grant = idx; return to IDLE. This guarantees at least one idle cycle between grants.
- Timeout:
  - The counter clears on entry to REQ and increments each cycle in REQ and READ.
  - When it equals timeout_cycles (nonzero): pulse timeout_evt and rd_abort, increment timeout_count (saturates at 255), go to RELEASE.
  - rd_done in the same cycle as expiry: done wins, no timeout.
- Latency:
  - interruptn low at edge 0 → layer_hold high after edge SYNC_STAGES+1 (3).
  - rd_req high HOLD_SETUP cycles after hold rises.
- enable low: no new grants; an in-flight transfer runs to completion.
- layer_mask cleared for the granted layer mid-transfer: the transfer completes; the mask only affects arbitration.
- rd_layer holds idx from HOLD_SETUP through RELEASE; 0 in IDLE.

Decomposition:
- Package compair_readout_pkg holds:
  - NLAYERS_DEFAULT;
  - LAYER_IDX_W = $clog2(NLAYERS);
  - enum sched_state_t {IDLE, HOLD_SETUP, REQ, READ, RELEASE}.
- Sub-module rr_arbiter: pending vector plus last_grant in; found flag plus index out; purely combinational priority rotate.
- Synchronizer: the existing shared sync cell, instanced NLAYERS wide.

Test Plan:
- Single layer:
  - Stimulus: interruptn[5] low, rd_ack 2 cycles after rd_req, rd_done 10 cycles later.
  - Response: hold[5] high 3 cycles after stimulus; rd_req after 4 more cycles with rd_layer = 5; hold[5] low 1 cycle after rd_done; busy low the next cycle.
- Round-robin:
  - Stimulus: layers 0, 7 and 19 held low, last_grant reset.
  - Response: grant order 0, 7, 19, 0, …; no layer granted twice while another is pending.
- Timeout:
  - Stimulus: timeout_cycles = 20; rd_ack given, rd_done never.
  - Response: timeout_evt and rd_abort pulse exactly 20 cycles after entering REQ; timeout_count = 1; hold released.
- Done vs timeout collision:
  - Stimulus: rd_done on the expiry cycle.
  - Response: no timeout_evt; timeout_count unchanged.
- Masking and enable:
  - Stimulus: layer_mask[3] = 0 with interruptn[3] low. Response: no grant.
  - Stimulus: enable dropped during READ. Response: the transfer completes and no further grant is issued.
- Reset mid-READ:
  - Stimulus: resn pulsed low.
  - Response: rd_req, hold and busy go 0 asynchronously; after release the first grant goes to the lowest pending index.
